// File: rtl/framebuffer_scanout_engine.sv
// Raster scanout of a packed 3-bpp framebuffer: three byte reads per 8-pixel group, then eight pixels out.
// One idle cycle precedes each read; a stalled pixel (pix_valid & !pix_ready) holds data/x/y and issues no reads.
module framebuffer_scanout_engine #(
    parameter int                H_PIX     = 640,
    parameter int                V_PIX     = 480,
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [2:0]        pix_data,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              frame_done
);

    localparam logic [9:0]        X_LAST    = 10'(H_PIX - 1);
    localparam logic [8:0]        Y_LAST    = 9'(V_PIX - 1);
    localparam logic [ADDR_W-1:0] GRP_BYTES = ADDR_W'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [23:0]       grp_q, grp_d;
    logic [2:0]        k_q, k_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              done_q, done_d;

    logic [1:0]        rd_off;
    logic [2:0]        pix_sel;
    logic              last_pix;

    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

    // Byte lane within the current group follows the read state.
    always_comb begin
        rd_off = 2'd0;
        case (state_q)
            S_RD1:   rd_off = 2'd1;
            S_RD2:   rd_off = 2'd2;
            default: rd_off = 2'd0;
        endcase
    end

    always_comb begin
        pix_sel = grp_q[2:0];
        case (k_q)
            3'd1:    pix_sel = grp_q[5:3];
            3'd2:    pix_sel = grp_q[8:6];
            3'd3:    pix_sel = grp_q[11:9];
            3'd4:    pix_sel = grp_q[14:12];
            3'd5:    pix_sel = grp_q[17:15];
            3'd6:    pix_sel = grp_q[20:18];
            3'd7:    pix_sel = grp_q[23:21];
            default: pix_sel = grp_q[2:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        grp_d   = grp_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        done_d  = 1'b0;

        if (abort) begin
            // Abort beats a same-cycle completion or handshake; late completions land in IDLE and are dropped.
            state_d = S_IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RD0;
                        x_d     = 10'd0;
                        y_d     = 9'd0;
                        k_d     = 3'd0;
                        base_d  = BASE_ADDR;
                    end
                end

                S_RD0, S_RD1, S_RD2: begin
                    if (!req_q) begin
                        req_d = 1'b1;
                    end else if (mem_rd_valid) begin
                        req_d = 1'b0;
                        if (state_q == S_RD0) begin
                            grp_d[7:0] = mem_rd_data;
                            state_d    = S_RD1;
                        end else if (state_q == S_RD1) begin
                            grp_d[15:8] = mem_rd_data;
                            state_d     = S_RD2;
                        end else begin
                            grp_d[23:16] = mem_rd_data;
                            state_d      = S_EMIT;
                        end
                    end
                end

                S_EMIT: begin
                    if (pix_ready) begin
                        k_d = k_q + 3'd1;
                        if (x_q == X_LAST) begin
                            x_d = 10'd0;
                            y_d = y_q + 9'd1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                        if (last_pix) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            x_d     = 10'd0;
                            y_d     = 9'd0;
                        end else if (k_q == 3'd7) begin
                            // Lines are a whole number of groups, so the next group is always contiguous.
                            base_d  = base_q + GRP_BYTES;
                            state_d = S_RD0;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            grp_q   <= 24'd0;
            k_q     <= 3'd0;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            base_q  <= BASE_ADDR;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            grp_q   <= grp_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign mem_rd_req  = req_q;
    assign mem_rd_addr = req_q ? (base_q + ADDR_W'(rd_off)) : '0;
    assign pix_valid   = (state_q == S_EMIT);
    assign pix_data    = pix_valid ? pix_sel : 3'd0;
    assign pix_x       = pix_valid ? x_q : 10'd0;
    assign pix_y       = pix_valid ? y_q : 9'd0;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_framebuffer_scanout_engine.sv
// Bench for framebuffer_scanout_engine: random memory latency and pixel backpressure against a pixel-index model.
module tb_framebuffer_scanout_engine;

    localparam int H_PIX   = 640;
    localparam int V_PIX   = 4;
    localparam int ADDR_W  = 17;
    localparam int NPIX    = H_PIX * V_PIX;
    localparam int LAST_RD = 3 * NPIX / 8 - 1;

    logic              clk;
    logic              rst_;
    logic              start;
    logic              abort;
    logic              busy;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_rd_valid;
    logic              pix_valid;
    logic              pix_ready;
    logic [2:0]        pix_data;
    logic [9:0]        pix_x;
    logic [8:0]        pix_y;
    logic              frame_done;

    logic              auto_mem;
    logic              auto_vld;
    logic [7:0]        auto_dat;
    logic              man_vld;
    logic [7:0]        man_dat;
    logic              rdy_rand;
    logic              stall_arm;
    logic              stall_done;
    logic [7:0]        mem [0:1023];
    logic [ADDR_W-1:0] last_addr;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int sb_n   = 0;

    assign mem_rd_valid = auto_mem ? auto_vld : man_vld;
    assign mem_rd_data  = auto_mem ? auto_dat : man_dat;

    framebuffer_scanout_engine #(
        .H_PIX    (H_PIX),
        .V_PIX    (V_PIX),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(17'd0)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_rd_valid(mem_rd_valid),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel n of the frame: group n/8, slot n%8 of the little-endian 24-bit word made of its three bytes.
    function automatic logic [2:0] model_pix(input int n);
        int          g;
        int          k;
        logic [23:0] w;
        g = n / 8;
        k = n % 8;
        w = {mem[3*g+2], mem[3*g+1], mem[3*g]};
        return w[3*k +: 3];
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h88;
        mem[1] = 8'hC6;
        mem[2] = 8'hFA;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_busy"},       32'(busy),        0);
        chk({pfx, "_req"},        32'(mem_rd_req),  0);
        chk({pfx, "_addr"},       32'(mem_rd_addr), 0);
        chk({pfx, "_pix_valid"},  32'(pix_valid),   0);
        chk({pfx, "_pix_data"},   32'(pix_data),    0);
        chk({pfx, "_pix_x"},      32'(pix_x),       0);
        chk({pfx, "_pix_y"},      32'(pix_y),       0);
        chk({pfx, "_frame_done"}, 32'(frame_done),  0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_req();
        int c;
        c = 0;
        while (!mem_rd_req && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("req_seen", 32'(mem_rd_req), 1);
    endtask

    // Full frame; an extra start is pulsed mid-frame and must be ignored.
    task automatic run_frame();
        int fd0;
        int cyc;
        fd0 = fd_cnt;
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        cyc = 0;
        while (fd_cnt == fd0 && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == 400);
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("frame_done_once", 32'(fd_cnt - fd0), 1);
        chk("busy_after_frame", 32'(busy), 0);
        chk("req_after_frame", 32'(mem_rd_req), 0);
    endtask

    task automatic abort_test();
        int fd0;
        fd0 = fd_cnt;
        auto_mem = 1'b0;
        pulse_start();
        wait_req();
        chk("ab_rd0_addr", 32'(mem_rd_addr), 0);
        man_dat = 8'h88;
        man_vld = 1'b1;
        @(posedge clk); #1;
        man_vld = 1'b0;
        wait_req();
        chk("ab_rd1_addr", 32'(mem_rd_addr), 1);
        abort   = 1'b1;
        man_dat = 8'hC6;
        man_vld = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        man_vld = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_req", 32'(mem_rd_req), 0);
        chk("ab_pix_valid", 32'(pix_valid), 0);
        // A completion arriving after the abort must not revive the scan.
        man_dat = 8'hFA;
        man_vld = 1'b1;
        @(posedge clk); #1;
        man_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("ab_quiet", 32'({busy, mem_rd_req, pix_valid, frame_done}), 0);
        end
        chk("ab_no_frame_done", 32'(fd_cnt - fd0), 0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_abort_req", 32'(mem_rd_req), 0);
        auto_mem = 1'b1;
    endtask

    task automatic reset_test();
        pulse_start();
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk_outputs_zero("mid_rst");
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_req", 32'(mem_rd_req), 0);
    endtask

    // Memory: checks the byte address sequence, holds each request 1-5 cycles, then completes it.
    initial begin : mem_resp
        logic [ADDR_W-1:0] a;
        int                lat;
        int                exp_addr;
        bit                wrap_done;
        auto_vld  = 1'b0;
        auto_dat  = 8'd0;
        last_addr = '0;
        exp_addr  = 0;
        wrap_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            auto_vld = 1'b0;
            if (!busy) begin
                exp_addr  = 0;
                wrap_done = 1'b0;
            end
            if (auto_mem && rst_ && mem_rd_req) begin
                a = mem_rd_addr;
                chk("rd_addr", 32'(a), exp_addr);
                if (sb_n == H_PIX && !wrap_done) begin
                    chk("wrap_addr", 32'(a), 3 * H_PIX / 8);
                    wrap_done = 1'b1;
                end
                last_addr = a;
                exp_addr++;
                lat = $urandom_range(1, 5);
                for (int i = 1; i < lat; i++) begin
                    @(posedge clk); #1;
                    if (rst_ && busy) begin
                        chk("addr_stable", 32'(mem_rd_addr), 32'(a));
                        chk("req_held", 32'(mem_rd_req), 1);
                    end
                end
                auto_dat = mem[a[9:0]];
                auto_vld = 1'b1;
            end
        end
    end

    // Consumer: ready always or 75% random; optionally one 10-cycle stall on a k=3 pixel.
    initial begin : rdy_drv
        logic [2:0] hd;
        logic [9:0] hx;
        logic [8:0] hy;
        pix_ready  = 1'b0;
        stall_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_arm && !stall_done && pix_valid && pix_x[2:0] == 3'd3) begin
                stall_done = 1'b1;
                hd = pix_data;
                hx = pix_x;
                hy = pix_y;
                pix_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(pix_valid), 1);
                    chk("bp_data", 32'(pix_data), 32'(hd));
                    chk("bp_x", 32'(pix_x), 32'(hx));
                    chk("bp_y", 32'(pix_y), 32'(hy));
                    chk("bp_no_req", 32'(mem_rd_req), 0);
                    @(posedge clk); #1;
                end
            end
            pix_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard: every accepted pixel against the model, frame totals at frame_done.
    initial begin : mon
        forever begin
            @(negedge clk);
            if (rst_ && pix_valid && pix_ready) begin
                chk("pix_x", 32'(pix_x), sb_n % H_PIX);
                chk("pix_y", 32'(pix_y), sb_n / H_PIX);
                chk("pix_data", 32'(pix_data), 32'(model_pix(sb_n)));
                if (sb_n < 8) chk("grp0_data", 32'(pix_data), sb_n);
                sb_n++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_pixels", sb_n, NPIX);
                chk("last_rd_addr", 32'(last_addr), LAST_RD);
            end
            if (!busy) sb_n = 0;
        end
    end

    initial begin
        rst_      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        auto_mem  = 1'b1;
        rdy_rand  = 1'b0;
        stall_arm = 1'b0;
        man_vld   = 1'b0;
        man_dat   = 8'd0;
        fill_mem();
        repeat (2) @(negedge clk);
        chk_outputs_zero("rst");
        @(negedge clk);
        rst_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);

        stall_arm = 1'b1;
        run_frame();
        stall_arm = 1'b0;
        chk("bp_stall_seen", 32'(stall_done), 1);

        fill_mem();
        rdy_rand = 1'b1;
        run_frame();

        abort_test();
        reset_test();

        fill_mem();
        run_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
